dir_cmd_gen: RTL and testbench

- Produces the direction commands (up/down/left/right) consumed by the 2048 game state machine from four raw push-buttons.
- Per button: synchronises, debounces and edge-detects the raw input.
- Arbitrates simultaneous presses and issues exactly one single-cycle direction pulse per physical press, only while the game FSM reports it is waiting for a move.
- Sits between the board button pins and the game FSM's direction inputs.

---
 rtl/dir_cmd_gen.sv | 135 +++++++++++++
 tb/tb_dir_cmd_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dir_cmd_gen.sv
// Direction command generator for the 2048 game FSM.
// Four raw push-buttons are synchronised, debounced and edge-detected.
// Each physical press becomes one single-cycle direction pulse,
// issued only while the game FSM reports it is waiting for a move.
module dir_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnL,
    input  logic BtnR,
    input  logic ready,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index order: 0 = up, 1 = down, 2 = left, 3 = right.
    // Lower index wins arbitration.
    logic [3:0] raw;
    assign raw = {BtnR, BtnL, BtnD, BtnU};

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       db_q, db_d;
    logic [3:0]       db_dly_q, db_dly_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       pending_q, pending_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       dir_q, dir_d;

    logic [3:0]       rise;
    assign rise = db_q & ~db_dly_q;

    // Synchroniser chain, debounce counters and level delay for edge detect.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Press capture and issue FSM: rises are only collected while idle,
    // and lower-priority simultaneous presses are dropped on issue.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                pending_d = pending_q | rise;
                if (ready && (pending_q != 4'b0000)) begin
                    if (pending_q[0])      dir_d = 2'd0;
                    else if (pending_q[1]) dir_d = 2'd1;
                    else if (pending_q[2]) dir_d = 2'd2;
                    else                   dir_d = 2'd3;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pending_d = 4'b0000;
                state_d   = S_RELEASE;
            end
            S_RELEASE: begin
                if (db_q == 4'b0000) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                pending_d = 4'b0000;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over every other update at the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_dly_q  <= '0;
            pending_q <= '0;
            state_q   <= S_IDLE;
            dir_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_dly_q  <= db_dly_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Moore output decode from registered state and latched direction.
    always_comb begin
        up    = (state_q == S_ISSUE) && (dir_q == 2'd0);
        down  = (state_q == S_ISSUE) && (dir_q == 2'd1);
        left  = (state_q == S_ISSUE) && (dir_q == 2'd2);
        right = (state_q == S_ISSUE) && (dir_q == 2'd3);
        busy  = (state_q == S_ISSUE) || (state_q == S_RELEASE);
    end

endmodule

// File: tb/tb_dir_cmd_gen.sv
// Testbench for dir_cmd_gen with DEBOUNCE_CYCLES = 4.
// Stimulus pushes the expected pulse (edge number, direction) into a
// scoreboard; an independent monitor pops and compares whenever a
// direction output is high.
module tb_dir_cmd_gen;

    localparam int N = 4;

    localparam int D_UP    = 0;
    localparam int D_DOWN  = 1;
    localparam int D_LEFT  = 2;
    localparam int D_RIGHT = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
    logic ready = 1'b0;
    logic up, down, left, right, busy;

    dir_cmd_gen #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .BtnU(BtnU),
        .BtnD(BtnD),
        .BtnL(BtnL),
        .BtnR(BtnR),
        .ready(ready),
        .up(up),
        .down(down),
        .left(left),
        .right(right),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Rising-edge counter: at a falling edge, edge_n is the number of the
    // rising edge just passed.
    int edge_n = 0;
    always @(posedge Clk) edge_n <= edge_n + 1;

    typedef struct {
        int at_edge;
        int dir;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic expect_pulse(input int at_edge, input int dir);
        exp_t e;
        e.at_edge = at_edge;
        e.dir     = dir;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int k);
        while (edge_n < k) @(negedge Clk);
    endtask

    // Monitor: every high direction output must match the scoreboard head.
    always @(negedge Clk) begin
        if (!Reset && (up || down || left || right)) begin
            int n_hi;
            int d;
            exp_t e;
            n_hi = int'(up) + int'(down) + int'(left) + int'(right);
            chk("onehot", n_hi, 1);
            d = up ? D_UP : (down ? D_DOWN : (left ? D_LEFT : D_RIGHT));
            if (sb.size() == 0) begin
                chk("unexpected_pulse_dir", d, -1);
            end else begin
                e = sb.pop_front();
                chk("pulse_edge", edge_n, e.at_edge);
                chk("pulse_dir", d, e.dir);
            end
        end
    end

    task automatic do_reset(input logic rdy);
        @(negedge Clk);
        Reset = 1'b1;
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        ready = rdy;
        @(negedge Clk);
        Reset = 1'b0;
        chk("reset_outputs", {27'd0, up, down, left, right, busy}, 0);
    endtask

    task automatic end_test(input string name, input int until_edge);
        wait_to(until_edge);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int base;

        // Test 1: up held, single pulse at edge 8, busy until release settles.
        do_reset(1'b1);
        base = edge_n;
        BtnU = 1'b1;
        expect_pulse(base + 8, D_UP);
        wait_to(base + 7);  chk("t1_busy_pre", busy, 0);
        wait_to(base + 8);  chk("t1_busy_issue", busy, 1);
        wait_to(base + 20); chk("t1_busy_held", busy, 1);
        BtnU = 1'b0;
        wait_to(base + 26); chk("t1_busy_release", busy, 1);
        wait_to(base + 27); chk("t1_busy_idle", busy, 0);
        end_test("t1_queue_empty", base + 35);

        // Test 2: 3-cycle glitch on left never produces a pulse.
        do_reset(1'b1);
        base = edge_n;
        BtnL = 1'b1;
        wait_to(base + 3);
        BtnL = 1'b0;
        wait_to(base + 8);  chk("t2_busy", busy, 0);
        end_test("t2_queue_empty", base + 25);

        // Test 3: down and right together, down wins, right dropped.
        do_reset(1'b1);
        base = edge_n;
        BtnD = 1'b1; BtnR = 1'b1;
        expect_pulse(base + 8, D_DOWN);
        wait_to(base + 12);
        BtnD = 1'b0; BtnR = 1'b0;
        wait_to(base + 18); chk("t3_busy_release", busy, 1);
        wait_to(base + 20); chk("t3_busy_idle", busy, 0);
        end_test("t3_queue_empty", base + 35);

        // Test 4: right press held pending while ready=0, issued after ready.
        do_reset(1'b0);
        base = edge_n;
        BtnR = 1'b1;
        wait_to(base + 10);
        BtnR = 1'b0;
        wait_to(base + 30); chk("t4_busy_wait", busy, 0);
        ready = 1'b1;
        expect_pulse(base + 31, D_RIGHT);
        wait_to(base + 33); chk("t4_busy_idle", busy, 0);
        end_test("t4_queue_empty", base + 40);

        // Test 5: reset at edge 8 truncates the pulse; re-debounce gives one.
        do_reset(1'b1);
        base = edge_n;
        BtnU = 1'b1;
        wait_to(base + 7);
        Reset = 1'b1;
        wait_to(base + 8);
        chk("t5_up_in_reset", up, 0);
        chk("t5_busy_in_reset", busy, 0);
        Reset = 1'b0;
        expect_pulse(base + 16, D_UP);
        wait_to(base + 22);
        BtnU = 1'b0;
        end_test("t5_queue_empty", base + 40);

        // Test 6: short bounce during hold and on release, still one pulse.
        do_reset(1'b1);
        base = edge_n;
        BtnU = 1'b1;
        expect_pulse(base + 8, D_UP);
        wait_to(base + 12); BtnU = 1'b0;
        wait_to(base + 14); BtnU = 1'b1;
        wait_to(base + 20); chk("t6_busy_held", busy, 1);
        wait_to(base + 24); BtnU = 1'b0;
        wait_to(base + 26); BtnU = 1'b1;
        wait_to(base + 28); BtnU = 1'b0;
        end_test("t6_queue_empty", base + 50);
        chk("t6_busy_final", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
